// File: rtl/ctrl_pkg.sv
// Shared control-pipeline types and encodings.
// Forwarding selects, ALUOp codes and per-stage control bundles.
package ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  typedef struct packed {
    logic alu_src;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
  } ex_ctrl_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  function automatic mem_ctrl_t to_mem(ex_ctrl_t c);
    mem_ctrl_t m;
    m.mem_read   = c.mem_read;
    m.mem_write  = c.mem_write;
    m.reg_write  = c.reg_write;
    m.mem_to_reg = c.mem_to_reg;
    return m;
  endfunction

  function automatic wb_ctrl_t to_wb(mem_ctrl_t c);
    wb_ctrl_t w;
    w.reg_write  = c.reg_write;
    w.mem_to_reg = c.mem_to_reg;
    return w;
  endfunction

endpackage

// File: rtl/ctrl_pipe_fwd_unit.sv
// EX-stage operand forwarding selects.
// EX/MEM producer wins over MEM/WB; x0 never forwards.
module fwd_unit
  import ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  output fwd_sel_e          fwd_a,
  output fwd_sel_e          fwd_b
);

  logic mem_ok;
  logic wb_ok;
  logic a_mem;
  logic a_wb;
  logic b_mem;
  logic b_wb;

  assign mem_ok = mem_reg_write & (|mem_rd);
  assign wb_ok  = wb_reg_write & (|wb_rd);

  assign a_mem = mem_ok & (mem_rd == ex_rs1);
  assign b_mem = mem_ok & (mem_rd == ex_rs2);
  assign a_wb  = wb_ok & (wb_rd == ex_rs1) & ~a_mem;
  assign b_wb  = wb_ok & (wb_rd == ex_rs2) & ~b_mem;

  // Operand A select, youngest producer first.
  always_comb begin
    fwd_a = FWD_REG;
    unique case (1'b1)
      a_mem:   fwd_a = FWD_EXMEM;
      a_wb:    fwd_a = FWD_MEMWB;
      default: fwd_a = FWD_REG;
    endcase
  end

  // Operand B select, youngest producer first.
  always_comb begin
    fwd_b = FWD_REG;
    unique case (1'b1)
      b_mem:   fwd_b = FWD_EXMEM;
      b_wb:    fwd_b = FWD_MEMWB;
      default: fwd_b = FWD_REG;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline ID/EX -> EX/MEM -> MEM/WB.
// Load-use stall, flush bubbles and forwarding selects.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [ALUOP_W-1:0] ALUOp_i,
  input  logic               ALUSrc_i,
  input  logic               MemRead_i,
  input  logic               MemWrite_i,
  input  logic               RegWrite_i,
  input  logic               MemtoReg_i,
  input  logic [REG_AW-1:0]  rs1_i,
  input  logic [REG_AW-1:0]  rs2_i,
  input  logic [REG_AW-1:0]  rd_i,
  input  logic               flush_i,
  output logic               stall_o,
  output logic [ALUOP_W-1:0] ex_ALUOp_o,
  output logic               ex_ALUSrc_o,
  output logic [1:0]         fwd_a_o,
  output logic [1:0]         fwd_b_o,
  output logic               mem_MemRead_o,
  output logic               mem_MemWrite_o,
  output logic               wb_RegWrite_o,
  output logic               wb_MemtoReg_o,
  output logic [REG_AW-1:0]  wb_rd_o
);

  ex_ctrl_t           id_ctrl;
  ex_ctrl_t           idex_ctrl;
  logic [ALUOP_W-1:0] idex_aluop;
  logic [REG_AW-1:0]  idex_rs1;
  logic [REG_AW-1:0]  idex_rs2;
  logic [REG_AW-1:0]  idex_rd;

  mem_ctrl_t          exmem_ctrl;
  logic [REG_AW-1:0]  exmem_rd;

  wb_ctrl_t           memwb_ctrl;
  logic [REG_AW-1:0]  memwb_rd;

  logic               ld_hit;
  logic               stall;
  logic               bubble;
  fwd_sel_e           fwd_a;
  fwd_sel_e           fwd_b;

  // ID-stage control bundle; MemtoReg masked so X never enters.
  always_comb begin
    id_ctrl            = '0;
    id_ctrl.alu_src    = ALUSrc_i;
    id_ctrl.mem_read   = MemRead_i;
    id_ctrl.mem_write  = MemWrite_i;
    id_ctrl.reg_write  = RegWrite_i;
    id_ctrl.mem_to_reg = MemtoReg_i & RegWrite_i;
  end

  // Load in EX whose result a source in ID needs.
  always_comb begin
    ld_hit = (idex_rd == rs1_i) | (idex_rd == rs2_i);
    stall  = idex_ctrl.mem_read & (|idex_rd) & ld_hit;
    bubble = stall | flush_i;
  end

  // ID/EX register; stall or flush inserts an all-zero bubble.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idex_ctrl  <= '0;
      idex_aluop <= '0;
      idex_rs1   <= '0;
      idex_rs2   <= '0;
      idex_rd    <= '0;
    end else if (bubble) begin
      idex_ctrl  <= '0;
      idex_aluop <= '0;
      idex_rs1   <= '0;
      idex_rs2   <= '0;
      idex_rd    <= '0;
    end else begin
      idex_ctrl  <= id_ctrl;
      idex_aluop <= ALUOp_i;
      idex_rs1   <= rs1_i;
      idex_rs2   <= rs2_i;
      idex_rd    <= rd_i;
    end
  end

  // EX/MEM register, always advances.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exmem_ctrl <= '0;
      exmem_rd   <= '0;
    end else begin
      exmem_ctrl <= to_mem(idex_ctrl);
      exmem_rd   <= idex_rd;
    end
  end

  // MEM/WB register, always advances.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      memwb_ctrl <= '0;
      memwb_rd   <= '0;
    end else begin
      memwb_ctrl <= to_wb(exmem_ctrl);
      memwb_rd   <= exmem_rd;
    end
  end

  fwd_unit #(
    .REG_AW(REG_AW)
  ) u_fwd (
    .ex_rs1       (idex_rs1),
    .ex_rs2       (idex_rs2),
    .mem_reg_write(exmem_ctrl.reg_write),
    .mem_rd       (exmem_rd),
    .wb_reg_write (memwb_ctrl.reg_write),
    .wb_rd        (memwb_rd),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b)
  );

  assign stall_o        = stall;
  assign ex_ALUOp_o     = idex_aluop;
  assign ex_ALUSrc_o    = idex_ctrl.alu_src;
  assign fwd_a_o        = fwd_a;
  assign fwd_b_o        = fwd_b;
  assign mem_MemRead_o  = exmem_ctrl.mem_read;
  assign mem_MemWrite_o = exmem_ctrl.mem_write;
  assign wb_RegWrite_o  = memwb_ctrl.reg_write;
  assign wb_MemtoReg_o  = memwb_ctrl.mem_to_reg;
  assign wb_rd_o        = memwb_rd;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe.
// Queue-based instruction model plus directed literal checks.
module tb_ctrl_pipe;

  logic       clk;
  logic       rst;
  logic [1:0] aluop;
  logic       alusrc, mr, mw, rw, m2r, flush;
  logic [4:0] rs1, rs2, rd;

  logic       stall_o, ex_alusrc_o, mem_mr_o, mem_mw_o;
  logic       wb_rw_o, wb_m2r_o;
  logic [1:0] ex_aluop_o, fwd_a_o, fwd_b_o;
  logic [4:0] wb_rd_o;

  int n_vec = 0;
  int n_bad = 0;

  ctrl_pipe #(.REG_AW(5), .ALUOP_W(2)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .ALUOp_i       (aluop),
    .ALUSrc_i      (alusrc),
    .MemRead_i     (mr),
    .MemWrite_i    (mw),
    .RegWrite_i    (rw),
    .MemtoReg_i    (m2r),
    .rs1_i         (rs1),
    .rs2_i         (rs2),
    .rd_i          (rd),
    .flush_i       (flush),
    .stall_o       (stall_o),
    .ex_ALUOp_o    (ex_aluop_o),
    .ex_ALUSrc_o   (ex_alusrc_o),
    .fwd_a_o       (fwd_a_o),
    .fwd_b_o       (fwd_b_o),
    .mem_MemRead_o (mem_mr_o),
    .mem_MemWrite_o(mem_mw_o),
    .wb_RegWrite_o (wb_rw_o),
    .wb_MemtoReg_o (wb_m2r_o),
    .wb_rd_o       (wb_rd_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction record; pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB.
  typedef struct {
    logic [1:0] op;
    logic       src, mr, mw, rw, m2r;
    logic [4:0] rs1, rs2, rd;
  } ins_t;

  ins_t pipe[$];

  function automatic ins_t nop_ins();
    ins_t z;
    z = '{op: 2'b00, src: 1'b0, mr: 1'b0, mw: 1'b0, rw: 1'b0,
          m2r: 1'b0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0};
    return z;
  endfunction

  task automatic model_reset();
    pipe.delete();
    repeat (3) pipe.push_back(nop_ins());
  endtask

  function automatic logic exp_stall();
    ins_t e;
    e = pipe[0];
    return e.mr && (e.rd != 0) && (e.rd == rs1 || e.rd == rs2);
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] src);
    ins_t m;
    ins_t w;
    m = pipe[1];
    w = pipe[2];
    if (m.rw && m.rd != 0 && m.rd == src) return 2'b10;
    if (w.rw && w.rd != 0 && w.rd == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("stall", {7'd0, stall_o}, {7'd0, exp_stall()});
    chk("ex_aluop", {6'd0, ex_aluop_o}, {6'd0, pipe[0].op});
    chk("ex_alusrc", {7'd0, ex_alusrc_o}, {7'd0, pipe[0].src});
    chk("fwd_a", {6'd0, fwd_a_o}, {6'd0, exp_fwd(pipe[0].rs1)});
    chk("fwd_b", {6'd0, fwd_b_o}, {6'd0, exp_fwd(pipe[0].rs2)});
    chk("mem_memread", {7'd0, mem_mr_o}, {7'd0, pipe[1].mr});
    chk("mem_memwrite", {7'd0, mem_mw_o}, {7'd0, pipe[1].mw});
    chk("wb_regwrite", {7'd0, wb_rw_o}, {7'd0, pipe[2].rw});
    chk("wb_memtoreg", {7'd0, wb_m2r_o}, {7'd0, pipe[2].m2r});
    chk("wb_rd", {3'd0, wb_rd_o}, {3'd0, pipe[2].rd});
  endtask

  task automatic advance();
    ins_t n;
    n = nop_ins();
    if (!(exp_stall() || flush)) begin
      n.op  = aluop;
      n.src = alusrc;
      n.mr  = mr;
      n.mw  = mw;
      n.rw  = rw;
      n.m2r = m2r & rw;
      n.rs1 = rs1;
      n.rs2 = rs2;
      n.rd  = rd;
    end
    pipe.push_front(n);
    void'(pipe.pop_back());
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic put(input logic [1:0] o, input logic s, input logic r,
                     input logic w, input logic g, input logic t,
                     input logic [4:0] a, input logic [4:0] b,
                     input logic [4:0] d, input logic f);
    aluop = o; alusrc = s; mr = r; mw = w; rw = g; m2r = t;
    rs1 = a; rs2 = b; rd = d; flush = f;
  endtask

  task automatic nop();
    put(2'b00, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
  endtask

  task automatic reset_now();
    rst = 1'b1;
    #1;
    chk("rst_ex_aluop", {6'd0, ex_aluop_o}, 8'd0);
    chk("rst_mem_memwrite", {7'd0, mem_mw_o}, 8'd0);
    chk("rst_mem_memread", {7'd0, mem_mr_o}, 8'd0);
    chk("rst_wb_regwrite", {7'd0, wb_rw_o}, 8'd0);
    chk("rst_wb_rd", {3'd0, wb_rd_o}, 8'd0);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    nop();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("init_stall", {7'd0, stall_o}, 8'd0);
    chk("init_fwd", {4'd0, fwd_a_o, fwd_b_o}, 8'd0);
    chk("init_wb_regwrite", {7'd0, wb_rw_o}, 8'd0);
    rst = 1'b0;
    tick();

    // R-type add x5, watch it travel.
    put(2'b10, 0, 0, 0, 1, 0, 5'd1, 5'd2, 5'd5, 0);
    tick();
    nop();
    chk("add_ex_aluop", {6'd0, ex_aluop_o}, 8'h02);
    tick();
    tick();
    chk("add_wb_regwrite", {7'd0, wb_rw_o}, 8'd1);
    chk("add_wb_rd", {3'd0, wb_rd_o}, 8'd5);

    // ld x6 ; add x7,x6,x1
    put(2'b00, 1, 1, 0, 1, 1, 5'd1, 5'd0, 5'd6, 0);
    tick();
    put(2'b10, 0, 0, 0, 1, 0, 5'd6, 5'd1, 5'd7, 0);
    #1;
    chk("lu_stall", {7'd0, stall_o}, 8'd1);
    tick();
    chk("lu_stall_gone", {7'd0, stall_o}, 8'd0);
    chk("lu_bubble_rw", {7'd0, ex_aluop_o}, 8'd0);
    tick();
    nop();
    chk("lu_fwd_a", {6'd0, fwd_a_o}, 8'h01);
    tick();
    tick();
    tick();

    // add x8 ; sub x9,x8,x8
    put(2'b10, 0, 0, 0, 1, 0, 5'd1, 5'd2, 5'd8, 0);
    tick();
    put(2'b10, 0, 0, 0, 1, 0, 5'd8, 5'd8, 5'd9, 0);
    tick();
    nop();
    chk("exmem_fwd", {4'd0, fwd_a_o, fwd_b_o}, 8'h0A);
    tick();
    tick();
    tick();
    // add x8 ; nop ; sub
    put(2'b10, 0, 0, 0, 1, 0, 5'd1, 5'd2, 5'd8, 0);
    tick();
    nop();
    tick();
    put(2'b10, 0, 0, 0, 1, 0, 5'd8, 5'd8, 5'd9, 0);
    tick();
    nop();
    chk("memwb_fwd", {4'd0, fwd_a_o, fwd_b_o}, 8'h05);
    tick();
    tick();
    tick();
    // add x8 ; add x8 ; sub
    put(2'b10, 0, 0, 0, 1, 0, 5'd1, 5'd2, 5'd8, 0);
    tick();
    tick();
    put(2'b10, 0, 0, 0, 1, 0, 5'd8, 5'd8, 5'd9, 0);
    tick();
    nop();
    chk("both_fwd", {4'd0, fwd_a_o, fwd_b_o}, 8'h0A);
    tick();
    tick();
    tick();

    // x0 writer then reader; ld x0 then reader.
    put(2'b10, 0, 0, 0, 1, 0, 5'd1, 5'd2, 5'd0, 0);
    tick();
    put(2'b10, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd3, 0);
    tick();
    nop();
    chk("x0_fwd", {4'd0, fwd_a_o, fwd_b_o}, 8'h00);
    put(2'b00, 1, 1, 0, 1, 1, 5'd1, 5'd0, 5'd0, 0);
    tick();
    put(2'b10, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd3, 0);
    #1;
    chk("x0_stall", {7'd0, stall_o}, 8'd0);
    tick();
    nop();
    tick();
    tick();

    // Flushed sd with unknown MemtoReg.
    put(2'b00, 1, 0, 1, 0, 1'bx, 5'd2, 5'd3, 5'd4, 1);
    tick();
    nop();
    tick();
    chk("flush_memwrite", {7'd0, mem_mw_o}, 8'd0);
    chk("flush_no_x", {7'd0, $isunknown({ex_aluop_o, ex_alusrc_o,
        mem_mr_o, mem_mw_o, wb_rw_o, wb_m2r_o, wb_rd_o,
        stall_o, fwd_a_o, fwd_b_o})}, 8'd0);
    tick();

    // Reset mid-flight with RegWrite in MEM.
    put(2'b10, 0, 0, 0, 1, 0, 5'd1, 5'd2, 5'd5, 0);
    tick();
    nop();
    tick();
    reset_now();
    tick();
    chk("rst_no_wb", {7'd0, wb_rw_o}, 8'd0);
    tick();

    // Randomized traffic, small register range to provoke hazards.
    for (int i = 0; i < 1500; i++) begin
      put(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
      tick();
      if ($urandom_range(0, 99) == 0) reset_now();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
